// File: rtl/bit_serializer_if.sv
// Byte-in / bit-out bus for the serializer: write handshake plus serial line and status.
interface bit_serializer_if;
  logic [7:0] wdata;
  logic       wen;
  logic       wready;
  logic       bitline;
  logic       busy;

  modport master (output wdata, output wen, input wready, input bitline, input busy);
  modport slave  (input wdata, input wen, output wready, output bitline, output busy);
endinterface

// File: rtl/bit_serializer.sv
// Byte FIFO feeding a framed serial line: sync 1, start 0, 8 data bits MSB first, stop 0, idle gap.
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | line low, waiting for a queued byte
// S_SYNC  | sync bit (1)
// S_START | start bit (0)
// S_DATA  | 8 data bits, shift register bit 7 on the line
// S_STOP  | stop bit (0)
// S_GAP   | IDLE_GAP low cycles before the next frame
module bit_serializer #(
  parameter int FIFO_DEPTH = 4,
  parameter int IDLE_GAP   = 1
) (
  input logic            clk,
  input logic            rst_n,
  bit_serializer_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [3:0]  GAP_LOAD = 4'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SYNC  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [2:0]    state;
  logic [7:0]    shreg;
  logic [2:0]    bit_cnt;
  logic [3:0]    gap_cnt;
  logic          bitline_q, busy_q;
  logic          push, pop, frame_end;

  assign bus.wready  = (count != FULL_CNT);
  assign bus.bitline = bitline_q;
  assign bus.busy    = busy_q;

  assign push = bus.wen && bus.wready;

  // A frame may chain straight into the next one at the end of STOP/GAP, so the
  // period stays 11+IDLE_GAP instead of paying an extra IDLE cycle.
  assign frame_end = (state == S_IDLE) ||
                     (state == S_STOP && IDLE_GAP == 0) ||
                     (state == S_GAP && gap_cnt == 4'd0);
  assign pop = frame_end && (count != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      bitline_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state)
        S_SYNC:  state <= S_START;
        S_START: begin
          state   <= S_DATA;
          bit_cnt <= '0;
        end
        S_DATA: begin
          shreg   <= {shreg[6:0], 1'b0};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) state <= S_STOP;
        end
        S_STOP: begin
          if (IDLE_GAP != 0) begin
            gap_cnt <= GAP_LOAD;
            state   <= S_GAP;
          end else if (pop) begin
            shreg <= mem[rd_ptr];
            state <= S_SYNC;
          end else begin
            state <= S_IDLE;
          end
        end
        S_GAP: begin
          if (gap_cnt != 4'd0) begin
            gap_cnt <= gap_cnt - 1'b1;
          end else if (pop) begin
            shreg <= mem[rd_ptr];
            state <= S_SYNC;
          end else begin
            state <= S_IDLE;
          end
        end
        default: begin
          if (pop) begin
            shreg <= mem[rd_ptr];
            state <= S_SYNC;
          end
        end
      endcase

      // Line and status are registered from the current state, one cycle behind it.
      case (state)
        S_SYNC:  bitline_q <= 1'b1;
        S_DATA:  bitline_q <= shreg[7];
        default: bitline_q <= 1'b0;
      endcase
      busy_q <= (state != S_IDLE) || (count != '0);
    end
  end
endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboarded bench: bytes pushed are queued as expectations, a line deserializer pops and compares.
module tb_bit_serializer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fails = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         sync_q[$];

  bit_serializer_if bus1 ();
  bit_serializer_if bus0 ();

  bit_serializer #(.FIFO_DEPTH(4), .IDLE_GAP(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  bit_serializer #(.FIFO_DEPTH(4), .IDLE_GAP(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream deserializer on the selected line.
  logic       line;
  int         m_st = 0;
  int         m_n = 0;
  logic [7:0] m_sh = 8'h00;
  assign line = sel ? bus1.bitline : bus0.bitline;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_st = 0;
    end else begin
      case (m_st)
        0: if (line === 1'b1) begin m_st = 1; sync_q.push_back(cyc); end
        1: if (line === 1'b0) begin m_st = 2; m_n = 0; end else m_st = 0;
        2: begin
          m_sh = {m_sh[6:0], line};
          m_n++;
          if (m_n == 8) m_st = 3;
        end
        default: begin
          if (line === 1'b0) rx_q.push_back(m_sh);
          m_st = 0;
        end
      endcase
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_queues;
    exp_q.delete();
    rx_q.delete();
    sync_q.delete();
  endtask

  task automatic wait_idle(input logic which);
    int n = 0;
    while (((which ? bus1.busy : bus0.busy) !== 1'b0) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      n_checks++; n_fails++;
      $display("FAIL idle_timeout: busy still %b after %0d cycles, required 0", which ? bus1.busy : bus0.busy, n);
    end
  endtask

  task automatic wait_rx(input int want, input int budget);
    int n = 0;
    while (rx_q.size() < want && n < budget) begin
      tick();
      n++;
    end
    if (rx_q.size() < want) begin
      n_checks++; n_fails++;
      $display("FAIL rx_timeout: got %0d bytes, required %0d", rx_q.size(), want);
    end
  endtask

  task automatic test_reset;
    bus1.wen = 1'b1; bus1.wdata = 8'h5A;
    bus0.wen = 1'b1; bus0.wdata = 8'hC3;
    rst_n = 1'b0;
    tick(); tick();
    bus1.wen = 1'b0; bus0.wen = 1'b0;
    n_checks++;
    if (bus1.bitline !== 1'b0) begin n_fails++; $display("FAIL reset_bitline: got %b, required 0", bus1.bitline); end
    n_checks++;
    if (bus1.wready !== 1'b1) begin n_fails++; $display("FAIL reset_wready: got %b, required 1", bus1.wready); end
    rst_n = 1'b1;
    repeat (4) tick();
    n_checks++;
    if (bus1.busy !== 1'b0) begin n_fails++; $display("FAIL reset_wen_discard1: busy %b, required 0", bus1.busy); end
    n_checks++;
    if (bus0.busy !== 1'b0) begin n_fails++; $display("FAIL reset_wen_discard0: busy %b, required 0", bus0.busy); end
    n_checks++;
    if (bus1.bitline !== 1'b0) begin n_fails++; $display("FAIL reset_idle_line: got %b, required 0", bus1.bitline); end
  endtask

  task automatic test_single;
    logic [7:0] b;
    logic [7:0] got;
    logic       eb, ebusy;
    sel = 1'b1;
    wait_idle(1'b1);
    clear_queues();
    b = 8'hA5;
    bus1.wdata = b; bus1.wen = 1'b1;
    exp_q.push_back(b);
    tick();
    bus1.wen = 1'b0; bus1.wdata = 8'hFF;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 2) eb = 1'b1;
      else if (k >= 4 && k <= 11) eb = b[11-k];
      else eb = 1'b0;
      ebusy = (k < 14);
      n_checks++;
      if (bus1.bitline !== eb) begin n_fails++; $display("FAIL single_bit t+%0d: got %b, required %b", k, bus1.bitline, eb); end
      n_checks++;
      if (bus1.busy !== ebusy) begin n_fails++; $display("FAIL single_busy t+%0d: got %b, required %b", k, bus1.busy, ebusy); end
    end
    n_checks++;
    if (rx_q.size() != 1) begin
      n_fails++; $display("FAIL single_rx_count: got %0d, required 1", rx_q.size());
    end else begin
      got = rx_q.pop_front(); b = exp_q.pop_front();
      n_checks++;
      if (got !== b) begin n_fails++; $display("FAIL single_rx_data: got %h, required %h", got, b); end
    end
  endtask

  task automatic test_loopback;
    logic [7:0] vals [4] = '{8'h00, 8'hFF, 8'h81, 8'h3C};
    logic [7:0] got, want;
    sel = 1'b1;
    wait_idle(1'b1);
    clear_queues();
    for (int i = 0; i < 4; i++) begin
      bus1.wdata = vals[i]; bus1.wen = 1'b1;
      exp_q.push_back(vals[i]);
      tick();
    end
    bus1.wen = 1'b0;
    wait_rx(4, 100);
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      got = rx_q.pop_front(); want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin n_fails++; $display("FAIL loopback_data: got %h, required %h", got, want); end
    end
    for (int i = 1; i < sync_q.size(); i++) begin
      n_checks++;
      if (sync_q[i] - sync_q[i-1] != 12) begin
        n_fails++; $display("FAIL loopback_period: got %0d cycles, required 12", sync_q[i] - sync_q[i-1]);
      end
    end
  endtask

  task automatic test_full;
    logic [7:0] got, want;
    logic       er;
    sel = 1'b1;
    wait_idle(1'b1);
    clear_queues();
    for (int i = 0; i < 6; i++) begin
      er = (i < 5);
      n_checks++;
      if (bus1.wready !== er) begin n_fails++; $display("FAIL full_wready push%0d: got %b, required %b", i, bus1.wready, er); end
      bus1.wdata = 8'(8'h40 + i); bus1.wen = 1'b1;
      if (i < 5) exp_q.push_back(8'(8'h40 + i));
      tick();
    end
    bus1.wen = 1'b0;
    n_checks++;
    if (bus1.wready !== 1'b0) begin n_fails++; $display("FAIL full_wready_hold: got %b, required 0", bus1.wready); end
    wait_rx(5, 120);
    repeat (40) tick();
    n_checks++;
    if (rx_q.size() != 5) begin n_fails++; $display("FAIL full_frame_count: got %0d, required 5", rx_q.size()); end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      got = rx_q.pop_front(); want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin n_fails++; $display("FAIL full_data: got %h, required %h", got, want); end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] got, want;
    sel = 1'b0;
    wait_idle(1'b0);
    clear_queues();
    bus0.wdata = 8'h12; bus0.wen = 1'b1; exp_q.push_back(8'h12); tick();
    bus0.wdata = 8'h34; bus0.wen = 1'b1; exp_q.push_back(8'h34); tick();
    bus0.wen = 1'b0;
    wait_rx(2, 60);
    n_checks++;
    if (sync_q.size() < 2) begin
      n_fails++; $display("FAIL b2b_sync_count: got %0d, required 2", sync_q.size());
    end else if (sync_q[1] - sync_q[0] != 11) begin
      n_fails++; $display("FAIL b2b_period: got %0d cycles, required 11", sync_q[1] - sync_q[0]);
    end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      got = rx_q.pop_front(); want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin n_fails++; $display("FAIL b2b_data: got %h, required %h", got, want); end
    end
    sel = 1'b1;
  endtask

  task automatic test_reset_mid;
    logic saw_one;
    sel = 1'b1;
    wait_idle(1'b1);
    clear_queues();
    bus1.wdata = 8'hF0; bus1.wen = 1'b1; tick();
    bus1.wdata = 8'hA1; tick();
    bus1.wdata = 8'hB2; tick();
    bus1.wen = 1'b0;
    repeat (5) tick();
    n_checks++;
    if (bus1.bitline !== 1'b1) begin n_fails++; $display("FAIL mid_bit4: got %b, required 1", bus1.bitline); end
    rst_n = 1'b0;
    tick();
    n_checks++;
    if (bus1.bitline !== 1'b0) begin n_fails++; $display("FAIL mid_reset_bitline: got %b, required 0", bus1.bitline); end
    n_checks++;
    if (bus1.busy !== 1'b0) begin n_fails++; $display("FAIL mid_reset_busy: got %b, required 0", bus1.busy); end
    n_checks++;
    if (bus1.wready !== 1'b1) begin n_fails++; $display("FAIL mid_reset_wready: got %b, required 1", bus1.wready); end
    rst_n = 1'b1;
    saw_one = 1'b0;
    repeat (40) begin
      tick();
      if (bus1.bitline === 1'b1) saw_one = 1'b1;
    end
    n_checks++;
    if (saw_one !== 1'b0) begin n_fails++; $display("FAIL mid_no_frames: line went high %b, required 0", saw_one); end
    n_checks++;
    if (rx_q.size() != 0) begin n_fails++; $display("FAIL mid_no_rden: got %0d bytes, required 0", rx_q.size()); end
  endtask

  initial begin
    bus1.wen = 1'b0; bus1.wdata = 8'h00;
    bus0.wen = 1'b0; bus0.wdata = 8'h00;
    test_reset();
    test_single();
    test_loopback();
    test_full();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, meaning input byte buffer depth in entries; legal values are powers of two from 2 to 16.
REQ-002 Parameter IDLE_GAP, default 1, meaning minimum number of BITLINE=0 idle cycles inserted after each stop bit; legal range is 0 to 15.
REQ-003 Port CLK  in  1  sole clock; all state changes on the rising edge.
REQ-004 Port RST_N  in  1  reset; synchronous and active-low.
REQ-005 Port WDATA  in  uint(8)  byte to transmit.
REQ-006 Port WEN  in  1  write request; WDATA is accepted on a rising edge where WEN=1 and WREADY=1.
REQ-007 Port WREADY  out  1  FIFO not full; combinational from the registered FIFO occupancy.
REQ-008 Port BITLINE  out  1  serial output; registered.
REQ-009 Port BUSY  out  1  high when a frame is in flight or the FIFO is non-empty.

Function
REQ-010 The frame format SHALL be: sync bit 1, start bit 0, 8 data bits MSB first, stop bit 0, each bit lasting exactly one CLK cycle.
REQ-011 The block SHALL implement states IDLE, SYNC, START, DATA, STOP and GAP.
REQ-012 In IDLE with the FIFO non-empty and the gap satisfied, the block SHALL pop the head byte into an 8-bit shift register and go to SYNC.
REQ-013 BITLINE SHALL be 1 in SYNC, 0 in START, shift-register bit 7 in DATA, 0 in STOP, and 0 in GAP and IDLE.
REQ-014 In DATA, the block SHALL shift left once per cycle, use a 3-bit bit counter, and leave DATA after the count reaches 7 (exactly 8 cycles).
REQ-015 After STOP, the block SHALL enter GAP for IDLE_GAP cycles using a 4-bit counter; when IDLE_GAP=0 it SHALL go directly to IDLE.
REQ-016 Latency: if WEN is accepted at edge t into an empty FIFO while in IDLE, BITLINE SHALL be 1 (sync) during cycle t+2.
REQ-017 Frame period: back-to-back frames SHALL start every 11+IDLE_GAP cycles when the FIFO stays non-empty.
REQ-018 A push while full SHALL be ignored, with WREADY=0 and no FIFO or occupancy change.
REQ-019 Push and pop on the same edge SHALL leave occupancy unchanged and preserve FIFO order.
REQ-020 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-021 The occupancy counter SHALL be log2(FIFO_DEPTH)+1 bits wide, so full and empty are distinguishable.
REQ-022 WDATA SHALL be ignored when the push is not accepted.
REQ-023 BUSY SHALL be 0 only in IDLE with the FIFO empty.

Reset
REQ-024 When RST_N=0 at a rising edge: state<=IDLE, BITLINE<=0, FIFO occupancy<=0, pointers<=0, bit and gap counters<=0, and the shift register is don't-care.
REQ-025 Reset mid-frame SHALL abort the frame; BITLINE SHALL be 0 in the cycle following the reset edge, and queued bytes are discarded.
REQ-026 A WEN asserted in the same cycle as RST_N=0 SHALL be discarded.
REQ-027 After reset, WREADY=1 and BUSY=0.

Verification
REQ-028 Single byte: push 0xA5 at t, IDLE_GAP=1 -> BITLINE sequence from t+2 is 1,0,1,0,1,0,0,1,0,1,0, then 0; BUSY falls at t+14.
REQ-029 Loopback: feed BITLINE into the downstream deserializer and push 0x00, 0xFF, 0x81, 0x3C back-to-back -> RDEN pulses four times with RDATA equal to the pushed bytes, in order.
REQ-030 Full FIFO (FIFO_DEPTH=4): push 6 bytes on consecutive cycles starting in IDLE -> the first 5 are accepted (one popped immediately), WREADY=0 while 4 are queued, the 6th is dropped, and only 5 frames are emitted.
REQ-031 Back-to-back with IDLE_GAP=0: push 0x12 and 0x34 -> the second sync bit occurs exactly 11 cycles after the first, and the deserializer reports both bytes.
REQ-032 Reset mid-operation: assert RST_N=0 during data bit 4 of 0xF0 with 2 bytes queued -> the next cycle has BITLINE=0, BUSY=0 and WREADY=1, no further frames are emitted, and the deserializer raises no RDEN.
